// File: rtl/exemem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exemem_pkg : shared widths, init value and state encoding for exemem_responder
// Rev 1.0
// ----------------------------------------------------------------------------
package exemem_pkg;
    localparam int unsigned c_data_w   = 16;
    localparam int unsigned c_addr_w   = 8;
    localparam int unsigned c_init_val = 0;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage
`default_nettype wire

// File: rtl/dp_ram_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dp_ram_core : storage array, two write ports (port A wins on same address),
//               two asynchronous read ports
// Rev 1.0
// ----------------------------------------------------------------------------
module dp_ram_core
    import exemem_pkg::*;
#(
    parameter int unsigned DATA_W = c_data_w,
    parameter int unsigned ADDR_W = c_addr_w
) (
    input  logic              clk,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] din_a,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] din_b,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);
    localparam int unsigned c_depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [c_depth];
    logic              w_b_dropped;

    assign w_b_dropped = we_a && (addr_a == addr_b);

    always_ff @(posedge clk) begin
        if (we_a) begin
            r_mem[addr_a] <= din_a;
        end
        if (we_b && !w_b_dropped) begin
            r_mem[addr_b] <= din_b;
        end
    end

    assign rd_data_a = r_mem[rd_addr_a];
    assign rd_data_b = r_mem[rd_addr_b];
endmodule
`default_nettype wire

// File: rtl/exemem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// exemem_responder : dual-port 16-bit data memory responder with post-reset
//                    clear sweep, write-through echo and collision flag
// Rev 1.0
// ----------------------------------------------------------------------------
module exemem_responder
    import exemem_pkg::*;
#(
    parameter int unsigned       DATA_W   = c_data_w,
    parameter int unsigned       ADDR_W   = c_addr_w,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(c_init_val)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] dataIn1,
    output logic [DATA_W-1:0] dataOut1,
    output logic              valid1,
    input  logic              req2,
    input  logic              we2,
    input  logic [ADDR_W-1:0] addr2,
    input  logic [DATA_W-1:0] dataIn2,
    output logic [DATA_W-1:0] dataOut2,
    output logic              valid2,
    output logic              ready,
    output logic              collision
);
    localparam logic [ADDR_W-1:0] c_last_addr = '1;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_sweep_cnt;

    logic              w_init;
    logic              w_acc1, w_acc2;
    logic              w_wr1, w_wr2;
    logic              w_same_addr;
    logic              w_ram_we_a;
    logic [ADDR_W-1:0] w_ram_addr_a;
    logic [DATA_W-1:0] w_ram_din_a;
    logic [DATA_W-1:0] w_rd1, w_rd2;
    logic [DATA_W-1:0] w_resp1, w_resp2;

    assign w_init      = (r_state == ST_INIT);
    assign ready       = (r_state == ST_RUN);
    assign w_acc1      = req1 && ready;
    assign w_acc2      = req2 && ready;
    assign w_wr1       = w_acc1 && we1;
    assign w_wr2       = w_acc2 && we2;
    assign w_same_addr = (addr1 == addr2);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_INIT;
            r_sweep_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_init) begin
                r_sweep_cnt <= r_sweep_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_init && (r_sweep_cnt == c_last_addr)) begin
            w_state_nxt = ST_RUN;
        end
    end

    // The clear sweep borrows write port A; requests are gated off meanwhile
    assign w_ram_we_a   = w_init ? 1'b1        : w_wr1;
    assign w_ram_addr_a = w_init ? r_sweep_cnt : addr1;
    assign w_ram_din_a  = w_init ? INIT_VAL    : dataIn1;

    dp_ram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .we_a      (w_ram_we_a),
        .addr_a    (w_ram_addr_a),
        .din_a     (w_ram_din_a),
        .we_b      (w_wr2),
        .addr_b    (addr2),
        .din_b     (dataIn2),
        .rd_addr_a (addr1),
        .rd_data_a (w_rd1),
        .rd_addr_b (addr2),
        .rd_data_b (w_rd2)
    );

    // Each response is the value the array holds after this edge's writes
    always_comb begin
        w_resp1 = w_rd1;
        if (w_wr1) begin
            w_resp1 = dataIn1;
        end else if (w_wr2 && w_same_addr) begin
            w_resp1 = dataIn2;
        end

        w_resp2 = w_rd2;
        if (w_wr1 && w_same_addr) begin
            w_resp2 = dataIn1;
        end else if (w_wr2) begin
            w_resp2 = dataIn2;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dataOut1  <= '0;
            dataOut2  <= '0;
            valid1    <= 1'b0;
            valid2    <= 1'b0;
            collision <= 1'b0;
        end else begin
            valid1    <= w_acc1;
            valid2    <= w_acc2;
            collision <= w_wr1 && w_wr2 && w_same_addr;
            if (w_acc1) begin
                dataOut1 <= w_resp1;
            end
            if (w_acc2) begin
                dataOut2 <= w_resp2;
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_exemem_responder.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_exemem_responder : directed vector table plus reset/sweep sequences
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_exemem_responder;
    logic        clk = 1'b0;
    logic        reset;
    logic        req1, we1, req2, we2;
    logic [7:0]  addr1, addr2;
    logic [15:0] dataIn1, dataIn2;
    logic [15:0] dataOut1, dataOut2;
    logic        valid1, valid2, ready, collision;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    exemem_responder dut (
        .clk       (clk),
        .reset     (reset),
        .req1      (req1),
        .we1       (we1),
        .addr1     (addr1),
        .dataIn1   (dataIn1),
        .dataOut1  (dataOut1),
        .valid1    (valid1),
        .req2      (req2),
        .we2       (we2),
        .addr2     (addr2),
        .dataIn2   (dataIn2),
        .dataOut2  (dataOut2),
        .valid2    (valid2),
        .ready     (ready),
        .collision (collision)
    );

    typedef struct {
        logic        req1;
        logic        we1;
        logic [7:0]  addr1;
        logic [15:0] din1;
        logic        req2;
        logic        we2;
        logic [7:0]  addr2;
        logic [15:0] din2;
        logic        v1;
        logic [15:0] d1;
        logic        v2;
        logic [15:0] d2;
        logic        col;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r1, input logic w1, input logic [7:0] a1, input logic [15:0] d1,
                         input logic r2, input logic w2, input logic [7:0] a2, input logic [15:0] d2);
        req1 = r1; we1 = w1; addr1 = a1; dataIn1 = d1;
        req2 = r2; we2 = w2; addr2 = a2; dataIn2 = d2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'd0, 16'd0, 1'b0, 1'b0, 8'd0, 16'd0);
    endtask

    // Runs the clear sweep with optional INIT-time requests; returns cycles until ready
    task automatic wait_ready(input logic poke, output int cycles, output logic spurious);
        cycles   = 0;
        spurious = 1'b0;
        while (!ready && cycles < 400) begin
            if (poke) drive(1'b1, 1'b1, 8'd9, 16'h5555, 1'b1, 1'b1, 8'd9, 16'h6666);
            @(posedge clk);
            #1;
            cycles++;
            if (valid1 || valid2 || collision) spurious = 1'b1;
        end
        idle();
    endtask

    initial begin
        int          cyc;
        logic        spur;
        string       nm;

        vecs[0]  = '{1,1,8'd1,16'd69,     1,1,8'd3,16'd21,     1,16'd69,    1,16'd21,    0};
        vecs[1]  = '{1,0,8'd1,16'd0,      1,0,8'd3,16'd0,      1,16'd69,    1,16'd21,    0};
        vecs[2]  = '{0,0,8'd0,16'd0,      0,0,8'd0,16'd0,      0,16'd69,    0,16'd21,    0};
        vecs[3]  = '{1,1,8'd5,16'h1111,   1,1,8'd5,16'h2222,   1,16'h1111,  1,16'h1111,  1};
        vecs[4]  = '{1,0,8'd5,16'd0,      1,0,8'd5,16'd0,      1,16'h1111,  1,16'h1111,  0};
        vecs[5]  = '{1,1,8'd7,16'hBEEF,   1,0,8'd7,16'd0,      1,16'hBEEF,  1,16'hBEEF,  0};
        vecs[6]  = '{1,0,8'd7,16'd0,      1,1,8'd7,16'h1234,   1,16'h1234,  1,16'h1234,  0};
        vecs[7]  = '{1,0,8'd9,16'd0,      1,0,8'd255,16'd0,    1,16'h0000,  1,16'h0000,  0};
        vecs[8]  = '{1,1,8'd255,16'hABCD, 1,0,8'd0,16'd0,      1,16'hABCD,  1,16'h0000,  0};
        vecs[9]  = '{1,0,8'd255,16'd0,    1,1,8'd0,16'h0F0F,   1,16'hABCD,  1,16'h0F0F,  0};
        vecs[10] = '{1,0,8'd0,16'd0,      0,0,8'd0,16'd0,      1,16'h0F0F,  0,16'h0F0F,  0};

        idle();
        reset = 1'b0;
        #12;
        check("rst_ready",     {31'd0, ready},     32'd0);
        check("rst_valid1",    {31'd0, valid1},    32'd0);
        check("rst_valid2",    {31'd0, valid2},    32'd0);
        check("rst_collision", {31'd0, collision}, 32'd0);
        check("rst_dataOut1",  {16'd0, dataOut1},  32'd0);
        check("rst_dataOut2",  {16'd0, dataOut2},  32'd0);

        @(negedge clk);
        reset = 1'b1;
        wait_ready(1'b1, cyc, spur);
        check("init_cycles",   cyc,            32'd256);
        check("init_no_pulse", {31'd0, spur},  32'd0);

        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].req1, vecs[i].we1, vecs[i].addr1, vecs[i].din1,
                  vecs[i].req2, vecs[i].we2, vecs[i].addr2, vecs[i].din2);
            @(posedge clk);
            #1;
            nm = $sformatf("vec%0d", i);
            check({nm, "_valid1"},    {31'd0, valid1},    {31'd0, vecs[i].v1});
            check({nm, "_dataOut1"},  {16'd0, dataOut1},  {16'd0, vecs[i].d1});
            check({nm, "_valid2"},    {31'd0, valid2},    {31'd0, vecs[i].v2});
            check({nm, "_dataOut2"},  {16'd0, dataOut2},  {16'd0, vecs[i].d2});
            check({nm, "_collision"}, {31'd0, collision}, {31'd0, vecs[i].col});
        end
        idle();

        // Write then reset mid-burst: outputs must clear without a clock edge
        drive(1'b1, 1'b1, 8'd1, 16'd69, 1'b1, 1'b1, 8'd2, 16'd70);
        @(posedge clk);
        #1;
        check("pre_rst_valid1", {31'd0, valid1}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        check("arst_valid1",   {31'd0, valid1},   32'd0);
        check("arst_valid2",   {31'd0, valid2},   32'd0);
        check("arst_dataOut1", {16'd0, dataOut1}, 32'd0);
        check("arst_dataOut2", {16'd0, dataOut2}, 32'd0);
        check("arst_ready",    {31'd0, ready},    32'd0);
        idle();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        wait_ready(1'b0, cyc, spur);
        check("reinit_cycles",   cyc,           32'd256);
        check("reinit_no_pulse", {31'd0, spur}, 32'd0);

        drive(1'b1, 1'b0, 8'd1, 16'd0, 1'b1, 1'b0, 8'd2, 16'd0);
        @(posedge clk);
        #1;
        check("post_rst_valid1",   {31'd0, valid1},   32'd1);
        check("post_rst_dataOut1", {16'd0, dataOut1}, 32'd0);
        check("post_rst_dataOut2", {16'd0, dataOut2}, 32'd0);
        idle();
        @(posedge clk);
        #1;
        check("idle_valid1", {31'd0, valid1}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
